r2sdf_stage_fx: RTL
===================

# r2sdf_stage_fx

Fixed-point, parametrised radix-2 single-path delay-feedback (R2SDF) butterfly stage. It is the next-generation replacement for the real-valued stage. Stages are chained in series to build a 2^LOG_N-point streaming FFT, one complex sample per accepted cycle, bit-reversed frame order. It adds a valid handshake, a synchronous reset, fixed-point arithmetic with rounding/saturation, optional per-stage 1/2 scaling, an inverse (conjugate-twiddle) mode and an external shared twiddle ROM port.

## Interface
- LOG_N, 3: log2 of FFT size; N = 2^LOG_N.
- STAGE, 1: stage index, 1..LOG_N; DEPTH = 2^(LOG_N-STAGE).
- W, 16: signed data width (re and im each).
- TW_W, 16: signed twiddle width, format Q1.(TW_W-2) (+1.0 = 2^(TW_W-2)).
- SCALE, 1: 1 = divide butterfly sums/differences by 2; 0 = saturate, no scaling.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample present this cycle.
- in_re, in_im  in  W  signed input sample.
- inverse  in  1  1 = use conjugate twiddle (IFFT); sampled with each accepted sample.
- tw_addr  out  max(LOG_N-1,1)  address into shared N/2-entry ROM of exp(-j2πk/N); combinational from state.
- tw_re, tw_im  in  TW_W  ROM data for tw_addr, same cycle (combinational ROM).
- out_valid  out  1  output sample valid.
- out_re, out_im  out  W  signed output sample.

## Operation
- Delay line: DEPTH complex entries, W bits each, FIFO order (entry DEPTH-1 = head).
- Sample counter cnt, (LOG_N-STAGE+1) bits, advances only on in_valid, wraps at 2*DEPTH. Phase = cnt MSB.
- Frame counter f, (STAGE-1) bits, increments when cnt wraps, wraps naturally. Absent when STAGE=1.
- tw_addr = bitrev_{STAGE-1}(f) << (LOG_N-STAGE). Constant 0 for STAGE=1.
- Twiddle used: (tw_re, tw_im), or (tw_re, -tw_im) when inverse=1. Negation saturates at -2^(TW_W-1).
- Phase 0 (fill), on accepted sample: out = head unchanged; the line shifts and the input enters the tail unmodified.
- Phase 1 (butterfly), on accepted sample:
  - p = in × twiddle (complex).
  - out = head + p; the line shifts and (head − p) enters the tail.
- Product arithmetic:
  - Full-precision W+TW_W+1 bits.
  - Add 2^(TW_W-3), then arithmetic shift right by TW_W-2 (round half up).
  - Saturate to W bits.
- Sum/difference arithmetic: computed in W+1 bits.
  - SCALE=1: arithmetic shift right 1 (floor), take W bits.
  - SCALE=0: saturate to [-2^(W-1), 2^(W-1)-1].
- Priming: out_valid stays low until DEPTH samples have been accepted since reset. After that, every accepted sample produces exactly one output.
- in_valid low: counters, delay line and outputs hold. out_valid = 0 next cycle.
- Reset mid-frame: everything returns to reset state; partial frames are discarded, priming restarts.

## Timing
- Latency: output registered, 1 cycle after the accepted sample.
- The butterfly sum for sample k (phase 1) and the sample k−DEPTH appear at stream distance DEPTH.
- Reset values (one cycle after rst high at clk edge):
  - out_valid = 0, out_re = out_im = 0.
  - cnt = 0, f = 0, priming count = 0, delay line all zeros.
  - tw_addr = 0.
- rst has priority over in_valid in the same cycle.
- tw_addr changes only on the clock edge that wraps cnt. ROM data must be stable the whole cycle.
- No back-pressure: the downstream consumer must accept every out_valid cycle.

## Test plan
- LOG_N=3, STAGE=1, SCALE=0; send re = 1..8 on cycles 0..7 (im=0), then 8 zeros -> outputs 6,8,10,12 at cycles 5..8 with out_valid; then -4,-4,-4,-4 at cycles 9..12; out_valid low on cycles 1..4.
- Same input with SCALE=1 -> outputs 3,4,5,6 then -2,-2,-2,-2.
- LOG_N=3, STAGE=2, stream of constant input (1000,0), tw ROM = exp(-j2πk/8) in Q1.14 -> tw_addr alternates 0 (frames even) and 2 (frames odd). Odd-frame phase-1 outputs equal 1000 + (0,-1000) = (1000,-1000). Repeat with inverse=1 -> (1000,+1000).
- Saturation: SCALE=0, STAGE=1, inputs 32767 at cycles 0 and 4 -> output 32767 (not wrapped). Inputs -32768 pair -> output -32768.
- Gapped input: the stimulus from the first test with in_valid deasserted on alternate cycles -> identical output sequence. out_valid is low in the cycle after each gap. tw_addr and cnt hold during gaps.
- Reset asserted at cycle 6 of a frame, then the first test restarted -> out_valid=0 and outputs zero immediately after reset; the restarted stream gives exactly the first test's results.

Source files
------------

// File: rtl/r2sdf_stage_fx_if.sv
// Stream + shared-twiddle-ROM bundle for one R2SDF stage.
// The master modport is the upstream producer/ROM owner; the slave is the stage itself.
interface r2sdf_stage_fx_if #(
  parameter int W    = 16,
  parameter int TW_W = 16,
  parameter int TA_W = 2
);
  logic                   in_valid;
  logic signed [W-1:0]    in_re;
  logic signed [W-1:0]    in_im;
  logic                   inverse;
  logic [TA_W-1:0]        tw_addr;
  logic signed [TW_W-1:0] tw_re;
  logic signed [TW_W-1:0] tw_im;
  logic                   out_valid;
  logic signed [W-1:0]    out_re;
  logic signed [W-1:0]    out_im;

  modport master (
    output in_valid, in_re, in_im, inverse, tw_re, tw_im,
    input  tw_addr, out_valid, out_re, out_im
  );

  modport slave (
    input  in_valid, in_re, in_im, inverse, tw_re, tw_im,
    output tw_addr, out_valid, out_re, out_im
  );
endinterface

// File: rtl/r2sdf_stage_fx.sv
// Fixed-point radix-2 single-path delay-feedback FFT stage with rounding,
// saturation, optional 1/2 scaling, conjugate-twiddle inverse mode and external ROM.
module r2sdf_stage_fx #(
  parameter int LOG_N = 3,
  parameter int STAGE = 1,
  parameter int W     = 16,
  parameter int TW_W  = 16,
  parameter int SCALE = 1
) (
  input logic            clk,
  input logic            rst,
  r2sdf_stage_fx_if.slave s
);
  localparam int DEPTH = 1 << (LOG_N - STAGE);
  localparam int CW    = LOG_N - STAGE + 1;
  localparam int TA_W  = (LOG_N > 1) ? LOG_N - 1 : 1;
  localparam int PW    = W + TW_W + 1;

  localparam logic signed [W-1:0]    D_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]    D_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [TW_W-1:0] TW_MAX = {1'b0, {(TW_W-1){1'b1}}};
  localparam logic signed [TW_W-1:0] TW_MIN = {1'b1, {(TW_W-1){1'b0}}};
  localparam logic signed [PW-1:0]   RND    = PW'(1) <<< (TW_W - 3);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    primed_q, primed_d;
  logic [DEPTH-1:0][W-1:0] dl_re_q, dl_re_d, dl_im_q, dl_im_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [W-1:0]     out_re_q, out_re_d, out_im_q, out_im_d;
  logic                    phase;

  assign phase = cnt_q[CW-1];

  // Twiddle address depends only on the frame counter, so it moves only on a cnt wrap.
  generate
    if (STAGE > 1) begin : g_frame
      logic [STAGE-2:0] f_q;
      logic [STAGE-2:0] f_rev;
      always_ff @(posedge clk) begin
        if (rst)                        f_q <= '0;
        else if (s.in_valid && &cnt_q)  f_q <= f_q + (STAGE-1)'(1);
      end
      always_comb begin
        f_rev = '0;
        for (int i = 0; i < STAGE-1; i++) f_rev[i] = f_q[STAGE-2-i];
      end
      assign s.tw_addr = TA_W'(f_rev) << (LOG_N - STAGE);
    end else begin : g_noframe
      assign s.tw_addr = TA_W'(0);
    end
  endgenerate

  function automatic logic signed [W-1:0] sat_p(input logic signed [PW-1:0] v);
    if (!v[PW-1] && |v[PW-2:W-1])  return D_MAX;
    if (v[PW-1] && !(&v[PW-2:W-1])) return D_MIN;
    return v[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] fit(input logic signed [W:0] v);
    if (SCALE != 0)     return v[W:1];
    if (v[W] != v[W-1]) return v[W] ? D_MIN : D_MAX;
    return v[W-1:0];
  endfunction

  logic signed [TW_W-1:0] tw_im_c;
  logic signed [PW-1:0]   a_re, a_im, c_re, c_im, p_re_f, p_im_f, p_re_r, p_im_r;
  logic signed [W-1:0]    p_re, p_im, head_re, head_im;
  logic signed [W:0]      sum_re, sum_im, dif_re, dif_im;

  always_comb begin
    tw_im_c = s.tw_im;
    if (s.inverse) tw_im_c = (s.tw_im == TW_MIN) ? TW_MAX : -s.tw_im;
    a_re    = PW'(s.in_re);
    a_im    = PW'(s.in_im);
    c_re    = PW'(s.tw_re);
    c_im    = PW'(tw_im_c);
    p_re_f  = a_re * c_re - a_im * c_im;
    p_im_f  = a_re * c_im + a_im * c_re;
    // Round half up before dropping the Q1.(TW_W-2) fraction bits.
    p_re_r  = (p_re_f + RND) >>> (TW_W - 2);
    p_im_r  = (p_im_f + RND) >>> (TW_W - 2);
    p_re    = sat_p(p_re_r);
    p_im    = sat_p(p_im_r);
    head_re = $signed(dl_re_q[DEPTH-1]);
    head_im = $signed(dl_im_q[DEPTH-1]);
    sum_re  = (W+1)'(head_re) + (W+1)'(p_re);
    sum_im  = (W+1)'(head_im) + (W+1)'(p_im);
    dif_re  = (W+1)'(head_re) - (W+1)'(p_re);
    dif_im  = (W+1)'(head_im) - (W+1)'(p_im);
  end

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    dl_re_d     = dl_re_q;
    dl_im_d     = dl_im_q;
    out_valid_d = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    if (s.in_valid) begin
      cnt_d       = cnt_q + CW'(1);
      primed_d    = primed_q | (cnt_q == CW'(DEPTH - 1));
      out_valid_d = primed_q;
      for (int i = DEPTH-1; i > 0; i--) begin
        dl_re_d[i] = dl_re_q[i-1];
        dl_im_d[i] = dl_im_q[i-1];
      end
      if (phase) begin
        out_re_d   = fit(sum_re);
        out_im_d   = fit(sum_im);
        dl_re_d[0] = fit(dif_re);
        dl_im_d[0] = fit(dif_im);
      end else begin
        out_re_d   = head_re;
        out_im_d   = head_im;
        dl_re_d[0] = s.in_re;
        dl_im_d[0] = s.in_im;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      dl_re_q     <= '0;
      dl_im_q     <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      dl_re_q     <= dl_re_d;
      dl_im_q     <= dl_im_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_re    = out_re_q;
  assign s.out_im    = out_im_q;
endmodule
